seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-segment 7-segment display bank.
- Sits directly upstream of the BCD-to-segment decoder: it feeds one 4-bit BCD digit at a time to the decoder's `d` input and drives the matching digit-enable line.
- Double-buffers the displayed value so updates apply only at frame boundaries (no tearing).
- Provides leading-zero blanking, decimal-point control and invalid-digit detection.

Parameters:
- NUM_DIGITS, 8, number of digits scanned (2..8).
- CLK_DIV, 10000, clock cycles per digit slot (>=2).
- SEL_ACTIVE_LOW, 1, 1: enabled digit driven 0; 0: enabled digit driven 1.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- bcd_in  input  4*NUM_DIGITS  digit i at [4i+3:4i]; digit 0 is rightmost.
- dp_in  input  NUM_DIGITS  decimal-point request per digit.
- load  input  1  single-cycle strobe; capture bcd_in/dp_in into the pending buffer.
- lzb_en  input  1  leading-zero blanking enable, sampled every cycle.
- digit_out  output  4  BCD code to the decoder `d` input.
- digit_sel  output  NUM_DIGITS  one-hot digit enable, polarity per SEL_ACTIVE_LOW.
- dp_out  output  1  decimal point for the current digit; ORed with decoder q[0] downstream.
- frame_done  output  1  one-cycle pulse at the end of each full scan.
- err  output  1  sticky; set when a captured digit > 9.

Behaviour:
- Reset (async, rst=1):
  - prescaler=0, idx=0.
  - active and pending buffers all zero; pending_valid=0; err=0.
  - digit_out=0, dp_out=0, frame_done=0.
  - digit_sel all inactive.
- Outputs are registered. On the first clk edge after rst deasserts, the outputs present slot 0.
- Prescaler:
  - Counts 0..CLK_DIV-1 and wraps.
  - tick is high while prescaler==CLK_DIV-1.
  - On a tick edge, idx advances (NUM_DIGITS-1 wraps to 0).
  - Outputs present the new idx on the same edge, so each slot is exactly CLK_DIV cycles.
- Slot output for index i:
  - digit_out = active[i], dp_out = active_dp[i], digit_sel enables bit i only.
  - Blanked slot: digit_sel all inactive, digit_out=0, dp_out=0. Blanking is done via select only, because the decoder has no code for blank.
- Blank conditions (either one blanks the slot):
  - (a) lzb_en=1, i>0, active digits NUM_DIGITS-1 down to i are all zero, and none of active_dp[NUM_DIGITS-1..i] is set.
  - (b) active[i] > 9.
- Digit 0 is never blanked by LZB.
- Frame boundary = the tick edge where idx wraps NUM_DIGITS-1 -> 0.
  - frame_done=1 for the following cycle only.
  - If pending_valid: active <= pending, pending_valid <= 0. Slot 0 of the new frame already shows the new data.
- load:
  - Captures bcd_in/dp_in into pending and sets pending_valid. A later load before the boundary overwrites pending (last wins).
  - If load coincides with a frame-boundary edge, bcd_in/dp_in go straight to active and pending_valid is cleared. Any older pending is discarded.
- err:
  - Set on any capture (pending or bypass) containing a nibble > 9.
  - Cleared only by rst.
- Reset asserted mid-scan: immediate return to reset state. Pending data is lost.
- No combinational path from inputs to outputs.

Test Plan:
- NUM_DIGITS=4, CLK_DIV=4; reset release with no load -> digit_sel (active-low) cycles 1110,1101,1011,0111 for 4 cycles each; digit_out=0 throughout; frame_done pulses every 16 cycles.
- load bcd_in=16'h1234 mid-frame -> current frame still shows 0000; next frame slot 0 shows digit_out=4, slot 3 shows 1; one frame_done precedes the change.
- lzb_en=1, active=16'h0070 -> slots 3 and 2 have digit_sel=1111; slot 1 shows 7; slot 0 shows 0.
- Same value with dp_in=4'b0100 -> slot 2 un-blanked, shows 0 with dp_out=1; slot 3 still blanked.
- load bcd_in=16'h1A23 -> err=1 and stays 1; slot 2 blanked; other digits shown; err clears only on rst.
- load on the exact frame-boundary edge with pending 16'h1111 already queued, bcd_in=16'h2222 -> new frame shows 2222; 1111 is never displayed.
- Assert rst during slot 2 -> all digit_sel inactive immediately; after release, slot 0 is shown with the active value 0000.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: double-buffered digits, leading-zero
// blanking, decimal points, invalid-digit flag. All outputs registered; one slot per CLK_DIV cycles.
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 10000,
    parameter int SEL_ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    lzb_en,
    output logic [3:0]              digit_out,
    output logic [NUM_DIGITS-1:0]   digit_sel,
    output logic                    dp_out,
    output logic                    frame_done,
    output logic                    err
);
    localparam int PW = $clog2(CLK_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_IDLE =
        (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [NUM_DIGITS-1:0] SEL_ONE = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

    logic [PW-1:0]         prescaler_q, prescaler_d;
    logic [IW-1:0]         idx_q, idx_d;
    digits_t               active_q, active_d, pending_q;
    logic [NUM_DIGITS-1:0] active_dp_q, active_dp_d, pending_dp_q;
    logic                  pending_valid_q;
    logic                  tick, boundary, bad_in, blank, run;
    logic [NUM_DIGITS-1:0] lead_zero, sel_on;
    logic [3:0]            cur_digit;
    digits_t               bcd_digits;

    assign bcd_digits = bcd_in;

    always_comb begin
        tick        = (prescaler_q == PRE_MAX);
        boundary    = tick && (idx_q == IDX_MAX);
        prescaler_d = tick ? '0 : prescaler_q + 1'b1;
        idx_d       = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end

        // A load on the boundary edge wins over anything still pending.
        active_d    = active_q;
        active_dp_d = active_dp_q;
        if (boundary) begin
            if (load) begin
                active_d    = bcd_digits;
                active_dp_d = dp_in;
            end else if (pending_valid_q) begin
                active_d    = pending_q;
                active_dp_d = pending_dp_q;
            end
        end

        bad_in = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (bcd_digits[j] > 4'd9) bad_in = 1'b1;
        end

        // lead_zero[j]: every digit from the top down to j is zero with no dp lit.
        run       = 1'b1;
        lead_zero = '0;
        for (int j = NUM_DIGITS - 1; j >= 0; j--) begin
            run          = run && (active_d[j] == 4'd0) && !active_dp_d[j];
            lead_zero[j] = run;
        end

        // Outputs are computed from next-state so they show the new slot on the tick edge.
        cur_digit = active_d[idx_d];
        blank     = (cur_digit > 4'd9) || (lzb_en && (idx_d != '0) && lead_zero[idx_d]);
        sel_on    = blank ? '0 : (SEL_ONE << idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q     <= '0;
            idx_q           <= '0;
            active_q        <= '0;
            active_dp_q     <= '0;
            pending_q       <= '0;
            pending_dp_q    <= '0;
            pending_valid_q <= 1'b0;
            err             <= 1'b0;
            digit_out       <= 4'd0;
            dp_out          <= 1'b0;
            frame_done      <= 1'b0;
            digit_sel       <= SEL_IDLE;
        end else begin
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            active_dp_q <= active_dp_d;
            if (boundary) begin
                pending_valid_q <= 1'b0;
            end else if (load) begin
                pending_q       <= bcd_digits;
                pending_dp_q    <= dp_in;
                pending_valid_q <= 1'b1;
            end
            err        <= err | (load & bad_in);
            frame_done <= boundary;
            digit_out  <= blank ? 4'd0 : cur_digit;
            dp_out     <= blank ? 1'b0 : active_dp_d[idx_d];
            digit_sel  <= sel_on ^ SEL_IDLE;
        end
    end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl (4 digits, 4 cycles/slot, active-low select);
// expected slot contents are queued per frame and popped as the scan produces them.
module tb_seg7_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] bcd_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lzb_en = 1'b0;
    logic [3:0]  digit_out;
    logic [3:0]  digit_sel;
    logic        dp_out, frame_done, err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] dig;
        logic       dp;
    } slot_t;
    slot_t exp_q[$];

    seg7_scan_ctrl #(.NUM_DIGITS(4), .CLK_DIV(4), .SEL_ACTIVE_LOW(1)) dut (
        .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
        .lzb_en(lzb_en), .digit_out(digit_out), .digit_sel(digit_sel),
        .dp_out(dp_out), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [3:0] sel, input logic [3:0] dig, input logic dp);
        slot_t s;
        s.sel = sel; s.dig = dig; s.dp = dp;
        exp_q.push_back(s);
    endtask

    task automatic wait_frame(input int gap);
        int cnt = 0;
        do begin
            @(negedge clk);
            load = 1'b0;
            cnt++;
        end while (!frame_done && cnt < 64);
        chk("frame_gap", 16'(cnt), 16'(gap));
    endtask

    // Checks one frame (4 slots, first and last cycle of each) and optionally fires loads
    // at given cycle offsets; offset 15 lands on the next frame-boundary edge.
    task automatic run_frame(input int gap,
                             input int la1, input logic [15:0] v1, input logic [3:0] p1,
                             input int la2, input logic [15:0] v2, input logic [3:0] p2);
        slot_t cur = '0;
        wait_frame(gap);
        for (int o = 0; o < 16; o++) begin
            if (o > 0) @(negedge clk);
            if (o == la1) begin
                load = 1'b1; bcd_in = v1; dp_in = p1;
            end else if (o == la2) begin
                load = 1'b1; bcd_in = v2; dp_in = p2;
            end else begin
                load = 1'b0;
            end
            if (o == 1) chk("frame_done_width", 16'(frame_done), 16'd0);
            if (o % 4 == 0) begin
                if (exp_q.size() == 0) chk("queue_empty", 16'd0, 16'd1);
                else cur = exp_q.pop_front();
            end
            if (o % 4 == 0 || o % 4 == 3) begin
                chk($sformatf("sel_s%0d_c%0d", o / 4, o % 4), 16'(digit_sel), 16'(cur.sel));
                chk($sformatf("dig_s%0d_c%0d", o / 4, o % 4), 16'(digit_out), 16'(cur.dig));
                chk($sformatf("dp_s%0d_c%0d", o / 4, o % 4), 16'(dp_out), 16'(cur.dp));
            end
        end
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("rst_sel", 16'(digit_sel), 16'hF);
        chk("rst_dig", 16'(digit_out), 16'h0);
        chk("rst_dp", 16'(dp_out), 16'h0);
        chk("rst_fd", 16'(frame_done), 16'h0);
        chk("rst_err", 16'(err), 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Frame A: blank value; 1234 loaded mid-frame must not show yet.
        push(4'b1110, 0, 0); push(4'b1101, 0, 0); push(4'b1011, 0, 0); push(4'b0111, 0, 0);
        run_frame(16, 6, 16'h1234, 4'b0000, -1, 16'h0, 4'b0000);
        chk("err_a", 16'(err), 16'h0);
        lzb_en = 1'b1;

        // Frame B: 1234 appears; queue 0070.
        push(4'b1110, 4, 0); push(4'b1101, 3, 0); push(4'b1011, 2, 0); push(4'b0111, 1, 0);
        run_frame(1, 6, 16'h0070, 4'b0000, -1, 16'h0, 4'b0000);

        // Frame C: leading zeros blanked; queue 0070 with dp on digit 2.
        push(4'b1110, 0, 0); push(4'b1101, 7, 0); push(4'b1111, 0, 0); push(4'b1111, 0, 0);
        run_frame(1, 6, 16'h0070, 4'b0100, -1, 16'h0, 4'b0000);
        chk("err_c", 16'(err), 16'h0);

        // Frame D: dp un-blanks digit 2; queue invalid 1A23.
        push(4'b1110, 0, 0); push(4'b1101, 7, 0); push(4'b1011, 0, 1); push(4'b1111, 0, 0);
        run_frame(1, 6, 16'h1A23, 4'b0000, -1, 16'h0, 4'b0000);
        chk("err_d", 16'(err), 16'h1);

        // Frame E: invalid digit blanked; 1111 queued, then 2222 on the boundary edge.
        push(4'b1110, 3, 0); push(4'b1101, 2, 0); push(4'b1111, 0, 0); push(4'b0111, 1, 0);
        run_frame(1, 6, 16'h1111, 4'b0000, 15, 16'h2222, 4'b0000);
        chk("err_e", 16'(err), 16'h1);

        // Frames F and G: 2222 held, 1111 never surfaces.
        push(4'b1110, 2, 0); push(4'b1101, 2, 0); push(4'b1011, 2, 0); push(4'b0111, 2, 0);
        run_frame(1, -1, 16'h0, 4'b0000, -1, 16'h0, 4'b0000);
        push(4'b1110, 2, 0); push(4'b1101, 2, 0); push(4'b1011, 2, 0); push(4'b0111, 2, 0);
        run_frame(1, -1, 16'h0, 4'b0000, -1, 16'h0, 4'b0000);
        chk("err_g", 16'(err), 16'h1);

        // Reset in the middle of slot 2.
        wait_frame(1);
        repeat (9) @(negedge clk);
        chk("pre_rst_sel", 16'(digit_sel), 16'b1011);
        rst = 1'b1;
        lzb_en = 1'b0;
        #1;
        chk("mid_rst_sel", 16'(digit_sel), 16'hF);
        chk("mid_rst_dig", 16'(digit_out), 16'h0);
        chk("mid_rst_err", 16'(err), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_sel", 16'(digit_sel), 16'b1110);
        chk("post_rst_dig", 16'(digit_out), 16'h0);
        chk("post_rst_err", 16'(err), 16'h0);

        // Pending data is lost: the first full frame after reset is still zeros.
        push(4'b1110, 0, 0); push(4'b1101, 0, 0); push(4'b1011, 0, 0); push(4'b0111, 0, 0);
        run_frame(15, -1, 16'h0, 4'b0000, -1, 16'h0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
